// File: rtl/timer_pkg.sv
// Shared types and widths for the ramen timer control path.
package timer_pkg;

    localparam int SEC_W       = 9;
    localparam int NUM_PRESETS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } ctrl_state_t;

    // Preset index wraps after the last preset back to the first.
    function automatic logic [1:0] next_preset(input logic [1:0] sel);
        return (sel >= 2'(NUM_PRESETS - 1)) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key cleaner: 2-FF synchroniser, then the output only follows the
// synchronised key after DEBOUNCE_CYC consecutive samples disagreeing with it.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_clean
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Any sample equal to the current output restarts the stability count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b11;
            cnt       <= '0;
            key_clean <= 1'b1;
        end else begin
            sync <= {sync[0], key_raw};
            if (sync[1] != key_clean) begin
                if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                    key_clean <= sync[1];
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ramen_timer_ctrl.sv
// Ramen timer sequencer: key events, run/pause/alarm FSM, seconds-remaining counter.
// Define RAMEN_CTRL_DEBOUNCE_EN to route each key through key_debounce.
module ramen_timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned PRESET_0     = 180,
    parameter int unsigned PRESET_1     = 240,
    parameter int unsigned PRESET_2     = 300,
    parameter int unsigned BLINK_HALF   = 5000,
    parameter int unsigned ALARM_SEC    = 30,
    parameter int unsigned DEBOUNCE_CYC = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       key_n,
    input  logic             tick_1s,
    output logic             count_en,
    output logic             count_clr,
    output logic [SEC_W-1:0] remain_sec,
    output logic [1:0]       preset_sel,
    output logic [1:0]       state_o,
    output logic             alarm,
    output logic             alarm_blink
);

    localparam int unsigned SEC_MAX = (1 << SEC_W) - 1;
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);
    localparam int ALARM_W = $clog2(ALARM_SEC + 1);

    if ((PRESET_0 < 1) || (PRESET_0 > SEC_MAX) ||
        (PRESET_1 < 1) || (PRESET_1 > SEC_MAX) ||
        (PRESET_2 < 1) || (PRESET_2 > SEC_MAX) ||
        (BLINK_HALF < 1) || (ALARM_SEC < 1) || (DEBOUNCE_CYC < 1)) begin : g_cfg_error
        $error("ramen_timer_ctrl: preset or counter parameter out of range");
    end

    ctrl_state_t        state, state_nx;
    logic [SEC_W-1:0]   remain_nx;
    logic [1:0]         preset_nx;
    logic               clr_nx;
    logic [1:0]         key_clean;
    logic [1:0]         key_prev;
    logic [1:0]         ev;
    logic               ev_go, ev_sel;
    logic [BLINK_W-1:0] blink_cnt;
    logic [ALARM_W-1:0] alarm_cnt;
    logic               alarm_done;

`ifdef RAMEN_CTRL_DEBOUNCE_EN
    for (genvar i = 0; i < 2; i++) begin : g_debounce
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_key_debounce (
            .clk      (clk),
            .rst      (rst),
            .key_raw  (key_n[i]),
            .key_clean(key_clean[i])
        );
    end
`else
    logic [1:0] key_sync1, key_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_sync1 <= 2'b11;
            key_sync2 <= 2'b11;
        end else begin
            key_sync1 <= key_n;
            key_sync2 <= key_sync1;
        end
    end

    assign key_clean = key_sync2;
`endif

    // A press is the falling edge of the active-low cleaned key.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev <= 2'b11;
            ev       <= 2'b00;
        end else begin
            key_prev <= key_clean;
            ev       <= key_prev & ~key_clean;
        end
    end

    // Both keys together is a cancel, so key 1 always takes priority.
    assign ev_sel     = ev[1];
    assign ev_go      = ev[0] & ~ev[1];
    assign alarm_done = (state == ALARM) && tick_1s && (alarm_cnt == ALARM_W'(ALARM_SEC - 1));
    assign state_o    = state;

    function automatic logic [SEC_W-1:0] preset_of(input logic [1:0] sel);
        case (sel)
            2'd1:    return SEC_W'(PRESET_1);
            2'd2:    return SEC_W'(PRESET_2);
            default: return SEC_W'(PRESET_0);
        endcase
    endfunction

    always_comb begin
        state_nx  = state;
        remain_nx = remain_sec;
        preset_nx = preset_sel;
        clr_nx    = 1'b0;
        case (state)
            IDLE: begin
                if (ev_sel) begin
                    preset_nx = next_preset(preset_sel);
                    remain_nx = preset_of(preset_nx);
                end else if (ev_go) begin
                    state_nx  = RUN;
                    clr_nx    = 1'b1;
                    remain_nx = preset_of(preset_sel);
                end
            end
            RUN: begin
                // The tick is applied first; reaching zero beats a pause request.
                if (tick_1s && (remain_sec != '0)) begin
                    remain_nx = remain_sec - SEC_W'(1);
                end
                if (ev_sel) begin
                    state_nx  = IDLE;
                    remain_nx = preset_of(preset_sel);
                end else if (tick_1s && (remain_sec == SEC_W'(1))) begin
                    state_nx = ALARM;
                end else if (ev_go) begin
                    state_nx = PAUSE;
                end
            end
            PAUSE: begin
                if (ev_sel) begin
                    state_nx  = IDLE;
                    remain_nx = preset_of(preset_sel);
                end else if (ev_go) begin
                    state_nx = RUN;
                end
            end
            ALARM: begin
                remain_nx = '0;
                if (ev_sel || ev_go || alarm_done) begin
                    state_nx  = IDLE;
                    remain_nx = preset_of(preset_sel);
                end
            end
            default: begin
                state_nx  = IDLE;
                remain_nx = preset_of(preset_sel);
            end
        endcase
    end

    // count_en and alarm are decoded from the registered state, one cycle behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remain_sec <= SEC_W'(PRESET_0);
            preset_sel <= 2'd0;
            count_clr  <= 1'b0;
            count_en   <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= state_nx;
            remain_sec <= remain_nx;
            preset_sel <= preset_nx;
            count_clr  <= clr_nx;
            count_en   <= (state == RUN);
            alarm      <= (state == ALARM);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state != ALARM)) begin
            alarm_cnt <= '0;
        end else if (tick_1s) begin
            alarm_cnt <= alarm_cnt + ALARM_W'(1);
        end
    end

    // First ALARM cycle (alarm not yet set) starts the blink high with a fresh count.
    always_ff @(posedge clk) begin
        if (rst || (state != ALARM)) begin
            blink_cnt   <= '0;
            alarm_blink <= 1'b0;
        end else if (!alarm) begin
            blink_cnt   <= '0;
            alarm_blink <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
            blink_cnt   <= '0;
            alarm_blink <= ~alarm_blink;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_ramen_timer_ctrl.sv
// Scoreboard bench for ramen_timer_ctrl: every output change is popped against a
// queue of hand-computed snapshots; RAMEN_CTRL_DEBOUNCE_EN selects the debounce timing.
module tb_ramen_timer_ctrl;
    import timer_pkg::*;

    localparam int P0   = 3;
    localparam int P1   = 5;
    localparam int P2   = 7;
    localparam int BH   = 4;
    localparam int AS   = 3;
    localparam int DC   = 5;
    localparam int HOLD = DC + 6;
`ifdef RAMEN_CTRL_DEBOUNCE_EN
    localparam int EV_LAT = 3 + DC;
`else
    localparam int EV_LAT = 3;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] key_n;
    logic       tick_1s;
    logic       count_en, count_clr, alarm, alarm_blink;
    logic [8:0] remain_sec;
    logic [1:0] preset_sel, state_o;

    ramen_timer_ctrl #(
        .PRESET_0(P0), .PRESET_1(P1), .PRESET_2(P2),
        .BLINK_HALF(BH), .ALARM_SEC(AS), .DEBOUNCE_CYC(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .tick_1s    (tick_1s),
        .count_en   (count_en),
        .count_clr  (count_clr),
        .remain_sec (remain_sec),
        .preset_sel (preset_sel),
        .state_o    (state_o),
        .alarm      (alarm),
        .alarm_blink(alarm_blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [8:0] rem;
        logic [1:0] ps;
        logic       en;
        logic       clr;
        logic       al;
        logic       bl;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
        string name;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;
    snap_t prev_snap;
    int    cyc      = 0;
    int    last_cyc = 0;

    function automatic snap_t cur_snap();
        snap_t s;
        s.st = state_o; s.rem = remain_sec; s.ps = preset_sel;
        s.en = count_en; s.clr = count_clr; s.al = alarm; s.bl = alarm_blink;
        return s;
    endfunction

    function automatic snap_t mk(input ctrl_state_t st, input int rem, input int ps,
                                 input bit en, input bit clr, input bit al, input bit bl);
        snap_t s;
        s.st = st; s.rem = 9'(rem); s.ps = 2'(ps);
        s.en = en; s.clr = clr; s.al = al; s.bl = bl;
        return s;
    endfunction

    function automatic string fmt(input snap_t s);
        return $sformatf("st=%0d rem=%0d ps=%0d en=%0b clr=%0b al=%0b bl=%0b",
                         s.st, s.rem, s.ps, s.en, s.clr, s.al, s.bl);
    endfunction

    // gap = cycles since the previous output change, 0 = not checked.
    task automatic push(input string nm, input snap_t s, input int gap);
        exp_t e;
        e.s = s; e.gap = gap; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: each change of the output bundle pops one expected snapshot.
    always @(negedge clk) begin
        snap_t c;
        exp_t  e;
        if (mon_en) begin
            cyc++;
            c = cur_snap();
            if (c != prev_snap) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_change: got %s, required no change", fmt(c));
                end else begin
                    e = exp_q.pop_front();
                    if ((c != e.s) || ((e.gap != 0) && ((cyc - last_cyc) != e.gap))) begin
                        n_fail++;
                        $display("[TB] FAIL %s: got %s gap %0d, required %s gap %0d",
                                 e.name, fmt(c), cyc - last_cyc, fmt(e.s), e.gap);
                    end
                end
                prev_snap = c;
                last_cyc  = cyc;
            end
        end
    end

    task automatic check_output(input string nm, input snap_t e);
        snap_t c;
        @(negedge clk);
        c = cur_snap();
        n_checks++;
        if (c != e) begin
            n_fail++;
            $display("[TB] FAIL %s: got %s, required %s", nm, fmt(c), fmt(e));
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d snapshots pending, required 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
            exp_q.delete();
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] keys);
        @(negedge clk);
        key_n = key_n & ~keys;
        repeat (HOLD) @(negedge clk);
        key_n = key_n | keys;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s = 1'b0;
    endtask

    task automatic start_run(input int rem, input int ps);
        push("run_clr", mk(RUN, rem, ps, 0, 1, 0, 0), 0);
        push("run_en",  mk(RUN, rem, ps, 1, 0, 0, 0), 1);
        apply_stimulus(2'b01);
        wait_drain(300);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; key_n = 2'b11; tick_1s = 1'b0;
        repeat (4) @(negedge clk);
        check_output("reset_state", mk(IDLE, P0, 0, 0, 0, 0, 0));
        prev_snap = cur_snap();
        mon_en    = 1'b1;
        rst       = 1'b0;

        // Preset cycling in IDLE.
        push("sel_1", mk(IDLE, P1, 1, 0, 0, 0, 0), 0); apply_stimulus(2'b10); wait_drain(300);
        push("sel_2", mk(IDLE, P2, 2, 0, 0, 0, 0), 0); apply_stimulus(2'b10); wait_drain(300);
        push("sel_0", mk(IDLE, P0, 0, 0, 0, 0, 0), 0); apply_stimulus(2'b10); wait_drain(300);

        // Run to zero, alarm blink, then automatic return after AS ticks.
        start_run(P0, 0);
        push("tick_2",      mk(RUN,   2, 0, 1, 0, 0, 0), 0);
        push("tick_1",      mk(RUN,   1, 0, 1, 0, 0, 0), 0);
        push("alarm_enter", mk(ALARM, 0, 0, 1, 0, 0, 0), 0);
        push("alarm_on",    mk(ALARM, 0, 0, 0, 0, 1, 1), 1);
        push("blink_lo_1",  mk(ALARM, 0, 0, 0, 0, 1, 0), BH);
        push("blink_hi_2",  mk(ALARM, 0, 0, 0, 0, 1, 1), BH);
        push("blink_lo_2",  mk(ALARM, 0, 0, 0, 0, 1, 0), BH);
        repeat (3) pulse_tick();
        wait_drain(300);
        push("blink_hi_3",  mk(ALARM, 0, 0, 0, 0, 1, 1), BH);
        push("alarm_auto",  mk(IDLE, P0, 0, 0, 0, 1, 1), 2);
        push("alarm_off",   mk(IDLE, P0, 0, 0, 0, 0, 0), 1);
        repeat (AS) pulse_tick();
        wait_drain(300);
        check_output("after_auto_idle", mk(IDLE, P0, 0, 0, 0, 0, 0));

        // Pause holds the count; resume does not clear.
        start_run(P0, 0);
        push("run_tick",  mk(RUN,   2, 0, 1, 0, 0, 0), 0); pulse_tick(); wait_drain(300);
        push("pause",     mk(PAUSE, 2, 0, 1, 0, 0, 0), 0);
        push("pause_en0", mk(PAUSE, 2, 0, 0, 0, 0, 0), 1);
        apply_stimulus(2'b01); wait_drain(300);
        repeat (2) pulse_tick();
        check_output("pause_hold", mk(PAUSE, 2, 0, 0, 0, 0, 0));
        push("resume",    mk(RUN, 2, 0, 0, 0, 0, 0), 0);
        push("resume_en", mk(RUN, 2, 0, 1, 0, 0, 0), 1);
        apply_stimulus(2'b01); wait_drain(300);

        // Both keys together cancels.
        push("cancel",     mk(IDLE, P0, 0, 1, 0, 0, 0), 0);
        push("cancel_en0", mk(IDLE, P0, 0, 0, 0, 0, 0), 1);
        apply_stimulus(2'b11); wait_drain(300);

        // Tick to zero coinciding with start/pause: alarm wins.
        start_run(P0, 0);
        push("t_2", mk(RUN, 2, 0, 1, 0, 0, 0), 0);
        push("t_1", mk(RUN, 1, 0, 1, 0, 0, 0), 0);
        repeat (2) pulse_tick();
        wait_drain(300);
        push("tick_ev0_alarm", mk(ALARM, 0, 0, 1, 0, 0, 0), 0);
        push("alarm_on_b",     mk(ALARM, 0, 0, 0, 0, 1, 1), 1);
        push("blink_lo_b",     mk(ALARM, 0, 0, 0, 0, 1, 0), BH);
        @(negedge clk);
        key_n[0] = 1'b0;
        repeat (EV_LAT) @(negedge clk);
        tick_1s = 1'b1;
        @(negedge clk);
        tick_1s  = 1'b0;
        key_n[0] = 1'b1;
        wait_drain(300);

        // Key event leaves ALARM.
        push("blink_hi_b", mk(ALARM, 0, 0, 0, 0, 1, 1), BH);
`ifdef RAMEN_CTRL_DEBOUNCE_EN
        push("blink_lo_c", mk(ALARM, 0, 0, 0, 0, 1, 0), BH);
        push("key_exit",   mk(IDLE, P0, 0, 0, 0, 1, 0), 2);
`else
        push("key_exit",   mk(IDLE, P0, 0, 0, 0, 1, 1), 1);
`endif
        push("key_exit_off", mk(IDLE, P0, 0, 0, 0, 0, 0), 1);
        apply_stimulus(2'b10); wait_drain(300);

        // Cancel from a non-zero preset reloads that preset; reset mid-run.
        push("sel_1b", mk(IDLE, P1, 1, 0, 0, 0, 0), 0); apply_stimulus(2'b10); wait_drain(300);
        start_run(P1, 1);
        push("p1_tick", mk(RUN, 4, 1, 1, 0, 0, 0), 0); pulse_tick(); wait_drain(300);
        push("p1_cancel",     mk(IDLE, P1, 1, 1, 0, 0, 0), 0);
        push("p1_cancel_en0", mk(IDLE, P1, 1, 0, 0, 0, 0), 1);
        apply_stimulus(2'b10); wait_drain(300);
        start_run(P1, 1);
        push("p1_tick_b", mk(RUN, 4, 1, 1, 0, 0, 0), 0); pulse_tick(); wait_drain(300);
        push("reset_mid", mk(IDLE, P0, 0, 0, 0, 0, 0), 0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_drain(300);
        check_output("after_reset_mid", mk(IDLE, P0, 0, 0, 0, 0, 0));

`ifdef RAMEN_CTRL_DEBOUNCE_EN
        // A 3-cycle glitch is shorter than the debounce window.
        @(negedge clk); key_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);
        check_output("glitch_no_event", mk(IDLE, P0, 0, 0, 0, 0, 0));
`endif

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL queue_empty: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
